// File: rtl/change_dispenser.sv
// Change-return hopper driver: splits a latched amount greedily into 5/2/1 coins
// and emits one fixed-width eject pulse per coin, each followed by a guard gap.
module change_dispenser #(
    parameter int unsigned COIN1_VALUE  = 1,
    parameter int unsigned COIN2_VALUE  = 2,
    parameter int unsigned COIN5_VALUE  = 5,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] amount,
    output logic       busy,
    output logic       done,
    output logic       eject_coin1,
    output logic       eject_coin2,
    output logic       eject_coin5,
    output logic [7:0] remaining,
    output logic [7:0] coins_dispensed
);

    localparam int unsigned VAL_W   = 8;
    localparam int unsigned MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned TIMER_W = (MAX_CYC + 1 > 2) ? $clog2(MAX_CYC + 1) : 1;

    localparam logic [VAL_W-1:0]   C1_VAL     = VAL_W'(COIN1_VALUE);
    localparam logic [VAL_W-1:0]   C2_VAL     = VAL_W'(COIN2_VALUE);
    localparam logic [VAL_W-1:0]   C5_VAL     = VAL_W'(COIN5_VALUE);
    localparam logic [VAL_W-1:0]   COUNT_MAX  = {VAL_W{1'b1}};
    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        PULSE  = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_e;

    state_e             state_q,     state_d;
    logic [TIMER_W-1:0] timer_q,     timer_d;
    logic [VAL_W-1:0]   remaining_q, remaining_d;
    logic [VAL_W-1:0]   coins_q,     coins_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               ej1_q,       ej1_d;
    logic               ej2_q,       ej2_d;
    logic               ej5_q,       ej5_d;

    logic               pick_vld;
    logic [VAL_W-1:0]   pick_val;
    logic               pick1, pick2, pick5;

    // Greedy coin choice, largest first; a coin is only chosen if it fits.
    always_comb begin
        pick1    = 1'b0;
        pick2    = 1'b0;
        pick5    = 1'b0;
        pick_val = '0;
        if (remaining_q >= C5_VAL) begin
            pick5    = 1'b1;
            pick_val = C5_VAL;
        end else if (remaining_q >= C2_VAL) begin
            pick2    = 1'b1;
            pick_val = C2_VAL;
        end else if (remaining_q >= C1_VAL) begin
            pick1    = 1'b1;
            pick_val = C1_VAL;
        end
        pick_vld = pick1 | pick2 | pick5;
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        coins_d     = coins_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ej1_d       = ej1_q;
        ej2_d       = ej2_q;
        ej5_d       = ej5_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    remaining_d = amount;
                    coins_d     = '0;
                    busy_d      = 1'b1;
                    state_d     = SELECT;
                end
            end

            SELECT: begin
                if (pick_vld) begin
                    remaining_d = remaining_q - pick_val;
                    coins_d     = (coins_q == COUNT_MAX) ? coins_q : coins_q + VAL_W'(1);
                    ej1_d       = pick1;
                    ej2_d       = pick2;
                    ej5_d       = pick5;
                    timer_d     = PULSE_LOAD;
                    state_d     = PULSE;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            PULSE: begin
                if (timer_q == '0) begin
                    ej1_d   = 1'b0;
                    ej2_d   = 1'b0;
                    ej5_d   = 1'b0;
                    timer_d = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            GAP: begin
                if (timer_q == '0) begin
                    state_d = SELECT;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                ej1_d   = 1'b0;
                ej2_d   = 1'b0;
                ej5_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops eject lines immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            remaining_q <= '0;
            coins_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ej1_q       <= 1'b0;
            ej2_q       <= 1'b0;
            ej5_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            coins_q     <= coins_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ej1_q       <= ej1_d;
            ej2_q       <= ej2_d;
            ej5_q       <= ej5_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign eject_coin1     = ej1_q;
    assign eject_coin2     = ej2_q;
    assign eject_coin5     = ej5_q;
    assign remaining       = remaining_q;
    assign coins_dispensed = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy model queues the expected pulses
// and completion per job; a negedge monitor pops and compares them as they appear.
module tb_change_dispenser;

    localparam int P = 4;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] amount = 8'd0;
    logic       busy, done, eject_coin1, eject_coin2, eject_coin5;
    logic [7:0] remaining, coins_dispensed;

    logic       start_u = 1'b0;
    logic [7:0] amount_u = 8'd0;
    logic       busy_u, done_u, ej1_u, ej2_u, ej5_u;
    logic [7:0] remaining_u, coins_u;

    change_dispenser dut (
        .clk(clk), .rst_n(rst_n), .start(start), .amount(amount),
        .busy(busy), .done(done),
        .eject_coin1(eject_coin1), .eject_coin2(eject_coin2), .eject_coin5(eject_coin5),
        .remaining(remaining), .coins_dispensed(coins_dispensed)
    );

    change_dispenser #(
        .COIN1_VALUE(2), .COIN2_VALUE(3), .COIN5_VALUE(5),
        .PULSE_CYCLES(P), .GAP_CYCLES(G)
    ) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start_u), .amount(amount_u),
        .busy(busy_u), .done(done_u),
        .eject_coin1(ej1_u), .eject_coin2(ej2_u), .eject_coin5(ej5_u),
        .remaining(remaining_u), .coins_dispensed(coins_u)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct {
        int kind;   // 1/2/5 = eject pulse, 0 = done
        int cyc;
        int rem;
        int coins;
    } ev_t;

    ev_t exp_q[$];
    int  job_edge = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int rel_cyc();
        return edge_cnt - job_edge + 1;
    endfunction

    // Greedy 5/2/1 reference for the default-parameter instance.
    function automatic void push_model(input int amt);
        int  rem = amt;
        int  n = 0;
        ev_t e;
        while (rem >= 1) begin
            if (rem >= 5) begin e.kind = 5; rem -= 5; end
            else if (rem >= 2) begin e.kind = 2; rem -= 2; end
            else begin e.kind = 1; rem -= 1; end
            e.cyc = 2 + n * (1 + P + G);
            e.rem = 0;
            e.coins = 0;
            exp_q.push_back(e);
            n++;
        end
        e.kind  = 0;
        e.cyc   = n * (1 + P + G) + 2;
        e.rem   = rem;
        e.coins = (n > 255) ? 255 : n;
        exp_q.push_back(e);
    endfunction

    logic [2:0] mon_prev = 3'b000;
    logic [2:0] mon_cur;
    int         mon_width = 0;
    int         mon_kind;
    ev_t        mon_ev;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev  = 3'b000;
            mon_width = 0;
        end else begin
            mon_cur = {eject_coin5, eject_coin2, eject_coin1};
            if ($countones(mon_cur) > 1)
                check_eq("eject_onehot", $countones(mon_cur), 1);
            if (mon_cur != 3'b000 && mon_prev == 3'b000) begin
                mon_kind  = eject_coin5 ? 5 : (eject_coin2 ? 2 : 1);
                mon_width = 1;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_pulse", mon_kind, 0);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check_eq("pulse_kind", mon_kind, mon_ev.kind);
                    check_eq("pulse_cycle", rel_cyc(), mon_ev.cyc);
                end
            end else if (mon_cur != 3'b000) begin
                mon_width++;
            end else if (mon_prev != 3'b000) begin
                check_eq("pulse_width", mon_width, P);
            end
            mon_prev = mon_cur;

            if (done) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_done", 1, 0);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check_eq("done_kind", 0, mon_ev.kind);
                    check_eq("done_cycle", rel_cyc(), mon_ev.cyc);
                    check_eq("done_remaining", int'(remaining), mon_ev.rem);
                    check_eq("done_coins", int'(coins_dispensed), mon_ev.coins);
                    check_eq("done_busy", int'(busy), 0);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rel(input int r);
        for (int i = 0; i < 300 && rel_cyc() != r; i++) step();
        check_eq("reach_cycle", rel_cyc(), r);
    endtask

    task automatic run_job(input int amt);
        start    = 1'b1;
        amount   = 8'(amt);
        job_edge = edge_cnt + 1;
        push_model(amt);
        step();
        start = 1'b0;
        check_eq("busy_cycle1", int'(busy), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) step();
        check_eq("drain_timeout", exp_q.size(), 0);
        step();
    endtask

    initial begin
        int ucyc;
        int useen2;

        #2;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_eject", int'({eject_coin5, eject_coin2, eject_coin1}), 0);
        check_eq("rst_remaining", int'(remaining), 0);
        check_eq("rst_coins", int'(coins_dispensed), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check_eq("idle_done", int'(done), 0);

        // Mixed coins, zero amount, repeated largest coin
        run_job(8);  drain();
        run_job(0);  drain();
        run_job(17); drain();

        // Starts while busy and in DONE are ignored; the next IDLE start is taken
        run_job(8);
        wait_rel(6);
        start = 1'b1; amount = 8'd3;
        step();
        start = 1'b0;
        wait_rel(29);
        check_eq("in_done_cycle", int'(done), 1);
        start = 1'b1; amount = 8'd3;
        step();
        job_edge = edge_cnt + 1;
        push_model(3);
        step();
        start = 1'b0;
        check_eq("busy_after_idle_start", int'(busy), 1);
        drain();

        // Reset during the second pulse of an 8 job
        run_job(8);
        wait_rel(12);
        check_eq("mid_pulse_coin2", int'(eject_coin2), 1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_eject", int'({eject_coin5, eject_coin2, eject_coin1}), 0);
        check_eq("rst_mid_busy", int'(busy), 0);
        check_eq("rst_mid_remaining", int'(remaining), 0);
        check_eq("rst_mid_coins", int'(coins_dispensed), 0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (busy || done) check_eq("post_rst_idle", int'({busy, done}), 0);
        end
        check_eq("post_rst_busy", int'(busy), 0);
        run_job(5); drain();

        // Random amounts through the scoreboard
        for (int k = 0; k < 4; k++) begin
            run_job(int'($urandom_range(0, 60)));
            drain();
        end

        // Unreachable amount with coin set 2/3/5
        start_u = 1'b1; amount_u = 8'd1;
        step();
        start_u = 1'b0;
        check_eq("u_busy_c1", int'(busy_u), 1);
        step();
        check_eq("u_done_c2", int'(done_u), 1);
        check_eq("u_remaining", int'(remaining_u), 1);
        check_eq("u_coins", int'(coins_u), 0);
        check_eq("u_no_eject", int'({ej5_u, ej2_u, ej1_u}), 0);
        step();

        // 4 with coin set 2/3/5: one middle coin, then 1 left over
        start_u = 1'b1; amount_u = 8'd4;
        step();
        start_u = 1'b0;
        ucyc   = 1;
        useen2 = 0;
        for (int i = 0; i < 100 && !done_u; i++) begin
            step();
            ucyc++;
            if (ej2_u) useen2 = 1;
        end
        check_eq("u4_done_cycle", ucyc, 1 * (1 + P + G) + 2);
        check_eq("u4_seen_coin2", useen2, 1);
        check_eq("u4_remaining", int'(remaining_u), 1);
        check_eq("u4_coins", int'(coins_u), 1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Drives the change-return hopper for the vending machine. It is the output counterpart of the coin-input path: coins come in as single-cycle value pulses, and change goes out as solenoid pulses. On a `start` request it latches an amount and splits it greedily into 5/2/1 coins. Each coin is emitted as a fixed-width pulse on one of three eject lines, followed by a guard gap. The block sits between the vending controller, which computes the change owed, and the hopper drivers.

## Interface
- `COIN1_VALUE`, default 1: value of the smallest coin. Must be ≥1.
- `COIN2_VALUE`, default 2: value of the middle coin. Must be >`COIN1_VALUE`.
- `COIN5_VALUE`, default 5: value of the largest coin. Must be >`COIN2_VALUE`.
- `PULSE_CYCLES`, default 4: high time of each eject pulse. Must be ≥1.
- `GAP_CYCLES`, default 4: low time after each eject pulse. Must be ≥1.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to dispense; sampled only in IDLE.
- `amount`  in  8  change owed; latched on an accepted `start`.
- `busy`  out  1  high from SELECT through the last GAP.
- `done`  out  1  single-cycle completion pulse.
- `eject_coin1`  out  1  eject pulse for the smallest coin.
- `eject_coin2`  out  1  eject pulse for the middle coin.
- `eject_coin5`  out  1  eject pulse for the largest coin.
- `remaining`  out  8  value still owed; nonzero after `done` only if the amount is not reachable with the coin set.
- `coins_dispensed`  out  8  coins ejected in the current or last job; saturates at 255.

## Operation
- **States:** IDLE, SELECT, PULSE, GAP, DONE.
- **IDLE:** `busy`=0. If `start`=1, latch `remaining`←`amount`, clear `coins_dispensed`, and go to SELECT.
- **SELECT:** compare `remaining` against the coin values, largest first.
  - If `remaining`≥`COIN5_VALUE`, pick coin5; else if ≥`COIN2_VALUE`, pick coin2; else if ≥`COIN1_VALUE`, pick coin1.
  - On a pick: `remaining`←`remaining`−value, `coins_dispensed`+1 (saturating), load the timer, go to PULSE.
  - With no pick (including `amount`=0): go to DONE.
- **PULSE:** exactly one eject line, the picked one, is high for `PULSE_CYCLES` cycles. Then go to GAP.
- **GAP:** all eject lines low for `GAP_CYCLES` cycles. Then return to SELECT.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then IDLE.
- **Ignored starts:** `start` is ignored in every state except IDLE, including DONE. `amount` changes after latching have no effect.
- **Outputs:** all outputs are registered. The eject lines are mutually exclusive at all times.
- **Arithmetic:** subtraction is 8-bit and never underflows, because a coin is picked only if its value ≤ `remaining`. The timer is sized by $clog2 of max(`PULSE_CYCLES`, `GAP_CYCLES`)+1.

## Timing
- **Reset:** while `rst_n`=0, asynchronously force state=IDLE and all outputs to 0, including `remaining` and `coins_dispensed`. Asserting `rst_n` mid-pulse drops the eject line immediately. There is no resume after reset.
- **Accepted start:** `start` sampled high in IDLE at edge 0.
  - Cycle 1: SELECT, `busy`=1.
  - Cycles 2 to 1+P: first eject pulse (P = `PULSE_CYCLES`).
  - Cycles 2+P to 1+P+G: gap (G = `GAP_CYCLES`).
- **Per coin:** each coin costs 1+P+G cycles, counting its SELECT cycle.
- **Completion:** the final SELECT is followed by DONE (1 cycle), then IDLE.
  - Total from start to `done` = N·(1+P+G)+2, where N is the number of coins.
- **Output updates:** `remaining` and `coins_dispensed` update on the edge that enters PULSE.
- **Back-to-back jobs:** a new `start` is accepted at the earliest in the first IDLE cycle after DONE.

## Test plan
- **Mixed coins:** reset, then `start` with `amount`=8 (P=G=4) → pulses in order: `eject_coin5` cycles 2–5, `eject_coin2` cycles 11–14, `eject_coin1` cycles 20–23. `done` at cycle 29; `remaining`=0, `coins_dispensed`=3.
- **Zero amount:** `amount`=0 → `busy` high cycle 1 only, `done` at cycle 2, no eject pulse, `coins_dispensed`=0.
- **Repeated largest coin:** `amount`=17 → 5,5,5,2 (four pulses); `done` at cycle 4·9+2=38; `remaining`=0.
- **Ignored start:** pulse `start` again with `amount`=3 while `busy`, and also in the DONE cycle → both ignored. The original job completes unchanged. A `start` in the following IDLE cycle is accepted.
- **Reset mid-pulse:** drop `rst_n` during the second PULSE of an `amount`=8 job → the eject line falls the same cycle and every output reads 0. After release the block is in IDLE with no pending `done`.
- **Unreachable amount:** set parameters `COIN1_VALUE`=2, `COIN2_VALUE`=3, `COIN5_VALUE`=5 and `amount`=1 → no pulse, `done` at cycle 2, `remaining`=1.
